// File: rtl/siren_sequencer_pkg.sv
// Shared definitions for the siren sequencer: state encodings, default clock ratio,
// and the counter-width helper used by the sequencer and its prescaler.
package siren_sequencer_pkg;

    // 50 MHz system clock divided down to a 2 Hz tick.
    localparam int TICK_DIV_50MHZ = 25000000;

    // 2'd3 is never produced; the FSM recovers from it to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SIREN = 2'd1,
        ST_FLASH = 2'd2
    } state_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/siren_sequencer_if.sv
// Request/status bundle between the alarm controller and the siren sequencer.
interface siren_sequencer_if;
    logic       trigger;
    logic       cancel;
    logic       enable_siren;
    logic       two_hz_enable;
    logic       busy;
    logic [1:0] state_o;

    modport master (
        output trigger, cancel,
        input  enable_siren, two_hz_enable, busy, state_o
    );

    modport slave (
        input  trigger, cancel,
        output enable_siren, two_hz_enable, busy, state_o
    );
endinterface

// File: rtl/tick_divider.sv
// 2 Hz prescaler: counts 0..TICK_DIV-1 while running, tick on the terminal count.
module tick_divider
    import siren_sequencer_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_50MHZ
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick
);
    localparam int W = cnt_width(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] prescaler;

    assign tick = (prescaler == LAST);

    // Wrap at the terminal count; parked at zero when idle or when a state is (re)entered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
        end else if (clear || !run || tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + W'(1);
        end
    end
endmodule

// File: rtl/siren_sequencer.sv
// Alarm sequencer: SIREN phase of SIREN_TICKS 2 Hz periods, then FLASH phase of
// FLASH_TICKS single-cycle strobes, then back to idle. Cancel aborts at any time.
//   state    | meaning
//   ST_IDLE  | waiting for trigger, prescaler parked
//   ST_SIREN | enable_siren high, retrigger restarts the phase
//   ST_FLASH | strobe on every tick, trigger starts a fresh sequence
module siren_sequencer
    import siren_sequencer_pkg::*;
#(
    parameter int TICK_DIV    = TICK_DIV_50MHZ,
    parameter int SIREN_TICKS = 20,
    parameter int FLASH_TICKS = 8
) (
    input  logic               clock,
    input  logic               reset,
    siren_sequencer_if.slave   bus
);
    localparam int CNT_MAX = (SIREN_TICKS > FLASH_TICKS) ? SIREN_TICKS : FLASH_TICKS;
    localparam int CNT_W   = cnt_width(CNT_MAX);
    localparam logic [CNT_W-1:0] SIREN_LAST = CNT_W'(SIREN_TICKS - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_TICKS - 1);

    state_t             state, state_next;
    logic [CNT_W-1:0]   tick_cnt, tick_cnt_next;
    logic               clear;
    logic               run;
    logic               tick;

    assign run = (state == ST_SIREN) || (state == ST_FLASH);

    tick_divider #(.TICK_DIV(TICK_DIV)) u_tick_divider (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .run   (run),
        .tick  (tick)
    );

    // State and tick counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
        end else begin
            state    <= state_next;
            tick_cnt <= tick_cnt_next;
        end
    end

    // Next state in priority order; clear restarts the prescaler on any entry or retrigger.
    always_comb begin
        state_next    = state;
        tick_cnt_next = tick_cnt;
        clear         = 1'b0;
        if (bus.cancel) begin
            state_next    = ST_IDLE;
            tick_cnt_next = '0;
            clear         = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.trigger) begin
                        state_next    = ST_SIREN;
                        tick_cnt_next = '0;
                        clear         = 1'b1;
                    end
                end
                ST_SIREN: begin
                    if (bus.trigger) begin
                        tick_cnt_next = '0;
                        clear         = 1'b1;
                    end else if (tick) begin
                        if (tick_cnt == SIREN_LAST) begin
                            state_next    = ST_FLASH;
                            tick_cnt_next = '0;
                            clear         = 1'b1;
                        end else begin
                            tick_cnt_next = tick_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_FLASH: begin
                    if (bus.trigger) begin
                        state_next    = ST_SIREN;
                        tick_cnt_next = '0;
                        clear         = 1'b1;
                    end else if (tick) begin
                        if (tick_cnt == FLASH_LAST) begin
                            state_next    = ST_IDLE;
                            tick_cnt_next = '0;
                            clear         = 1'b1;
                        end else begin
                            tick_cnt_next = tick_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_next    = ST_IDLE;
                    tick_cnt_next = '0;
                    clear         = 1'b1;
                end
            endcase
        end
    end

    assign bus.enable_siren  = (state == ST_SIREN);
    assign bus.two_hz_enable = (state == ST_FLASH) && tick;
    assign bus.busy          = (state != ST_IDLE);
    assign bus.state_o       = state;
endmodule

// File: tb/tb_siren_sequencer.sv
// Scoreboard bench: each scenario pushes its per-cycle expected outputs, then drives
// trigger/cancel edge by edge and pops one expectation per cycle at the falling edge.
module tb_siren_sequencer;
    import siren_sequencer_pkg::*;

    localparam int TD = 4;
    localparam int ST = 3;
    localparam int FT = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;

    siren_sequencer_if bus ();

    siren_sequencer #(
        .TICK_DIV    (TD),
        .SIREN_TICKS (ST),
        .FLASH_TICKS (FT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // {enable_siren, two_hz_enable, busy, state_o}
    logic [4:0] sb_q[$];

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (en,strobe,busy,state)", tag, got, exp);
    endtask

    function automatic logic [4:0] observe();
        return {bus.enable_siren, bus.two_hz_enable, bus.busy, bus.state_o};
    endfunction

    task automatic exp_push(input logic [1:0] st, input logic strobe);
        sb_q.push_back({(st == ST_SIREN), strobe, (st != ST_IDLE), st});
    endtask

    // Cycles first..last in state st; strobe expected only on cycles sa and sb (0 = none).
    task automatic exp_span(input logic [1:0] st, input int first, input int last,
                            input int sa, input int sb);
        for (int c = first; c <= last; c++) exp_push(st, (c == sa) || (c == sb));
    endtask

    task automatic sb_pop(input string tag);
        logic [4:0] e;
        if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: got %b expected <no entry queued>", tag, observe());
        end else begin
            e = sb_q.pop_front();
            check(tag, observe(), e);
        end
    endtask

    // Drive edges 0..n-1 from the masks; cycle e+1 is sampled at the following falling edge.
    task automatic run_seq(input string name, input int n,
                           input logic [63:0] tm, input logic [63:0] cm);
        for (int e = 0; e < n; e++) begin
            bus.trigger = tm[e];
            bus.cancel  = cm[e];
            @(posedge clock);
            @(negedge clock);
            bus.trigger = 1'b0;
            bus.cancel  = 1'b0;
            sb_pop($sformatf("%s_c%0d", name, e + 1));
        end
    endtask

    task automatic basic(input string name);
        exp_span(ST_SIREN, 1, 12, 0, 0);
        exp_span(ST_FLASH, 13, 20, 16, 20);
        exp_span(ST_IDLE, 21, 24, 0, 0);
        run_seq(name, 24, 64'd1, 64'd0);
    endtask

    initial begin
        bus.trigger = 1'b0;
        bus.cancel  = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        exp_push(ST_IDLE, 1'b0);
        sb_pop("reset_state");
        reset = 1'b1;

        basic("basic");

        // Retrigger during SIREN at edge 6
        exp_span(ST_SIREN, 1, 18, 0, 0);
        exp_span(ST_FLASH, 19, 26, 22, 26);
        exp_span(ST_IDLE, 27, 30, 0, 0);
        run_seq("retrig", 30, (64'd1 << 0) | (64'd1 << 6), 64'd0);

        // Cancel during FLASH at edge 14
        exp_span(ST_SIREN, 1, 12, 0, 0);
        exp_span(ST_FLASH, 13, 14, 0, 0);
        exp_span(ST_IDLE, 15, 20, 0, 0);
        run_seq("cancel", 20, 64'd1, 64'd1 << 14);

        // Trigger and cancel together in IDLE
        exp_span(ST_IDLE, 1, 4, 0, 0);
        run_seq("both", 4, 64'd1, 64'd1);

        // Trigger during FLASH at edge 17 starts a full fresh sequence
        exp_span(ST_SIREN, 1, 12, 0, 0);
        exp_span(ST_FLASH, 13, 17, 16, 0);
        exp_span(ST_SIREN, 18, 29, 0, 0);
        exp_span(ST_FLASH, 30, 37, 33, 37);
        exp_span(ST_IDLE, 38, 41, 0, 0);
        run_seq("flash_trig", 41, (64'd1 << 0) | (64'd1 << 17), 64'd0);

        // Asynchronous reset in the middle of cycle 9
        exp_span(ST_SIREN, 1, 9, 0, 0);
        run_seq("pre_rst", 9, 64'd1, 64'd0);
        #2 reset = 1'b0;
        #1;
        exp_push(ST_IDLE, 1'b0);
        sb_pop("rst_async");
        @(posedge clock);
        @(negedge clock);
        exp_push(ST_IDLE, 1'b0);
        sb_pop("rst_hold");
        reset = 1'b1;
        basic("post_rst");

        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL sb_drain: got %0d entries left expected 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
